// File: rtl/button_conditioner_pkg.sv
// Shared constants for the pushbutton front end and player movement.
// Timing defaults assume a 25 MHz pixel clock.
// Also holds the fixed-priority pick used by the move arbiter.
package button_conditioner_pkg;

    localparam int NUM_BTN             = 4;
    localparam int PLAYER_SPEED        = 1;         // grid cells per move pulse
    localparam int DEBOUNCE_CYCLES_DEF = 250000;    // 10 ms
    localparam int REPEAT_DELAY_DEF    = 12500000;  // 0.5 s
    localparam int REPEAT_PERIOD_DEF   = 5000000;   // 0.2 s
    localparam int CNT_WIDTH_DEF       = 24;

    // One-hot grant of the lowest-index (highest-priority) request; losers are dropped.
    function automatic logic [NUM_BTN-1:0] pick_highest(input logic [NUM_BTN-1:0] req);
        logic [NUM_BTN-1:0] grant;
        grant = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button: 2-flop synchroniser, debounce counter, press/auto-repeat FSM.
// level_o is registered; req_o is a combinational request meant to be registered by the arbiter.
// Requests on a rising level edge and on each repeat terminal count; a falling edge kills all requests.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic req_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_e;

    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RD_LAST = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] RP_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);

    logic                 meta_q, sync_q;
    logic                 level_q, level_d;
    logic [CNT_WIDTH-1:0] db_cnt_q, db_cnt_d;
    logic [CNT_WIDTH-1:0] rep_cnt_q;
    state_e               state_q;

    logic mismatch, flip, rise, fall, delay_hit, repeat_hit;

    assign mismatch   = sync_q ^ level_q;
    assign flip       = mismatch && (db_cnt_q == DB_LAST);
    assign rise       = flip &  sync_q;
    assign fall       = flip & ~sync_q;
    assign delay_hit  = (state_q == DELAY)  && (rep_cnt_q == RD_LAST);
    assign repeat_hit = (state_q == REPEAT) && (rep_cnt_q == RP_LAST);

    // Two plain flops bring the asynchronous button into the clock domain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
        end
    end

    // Debounce next state: count consecutive mismatches, flip the level on the last one.
    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        if (mismatch) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = sync_q;
            end else begin
                db_cnt_d = db_cnt_q + ONE;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_q  <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Press / delay / repeat sequencing; a release drops straight back to IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rep_cnt_q <= '0;
        end else if (fall) begin
            state_q   <= IDLE;
            rep_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    rep_cnt_q <= '0;
                    if (rise) state_q <= DELAY;
                end
                DELAY: begin
                    if (rep_cnt_q == RD_LAST) begin
                        rep_cnt_q <= '0;
                        if (REPEAT_EN) state_q <= REPEAT;
                    end else begin
                        rep_cnt_q <= rep_cnt_q + ONE;
                    end
                end
                REPEAT: begin
                    if (rep_cnt_q == RP_LAST) rep_cnt_q <= '0;
                    else                      rep_cnt_q <= rep_cnt_q + ONE;
                end
                default: begin
                    state_q   <= IDLE;
                    rep_cnt_q <= '0;
                end
            endcase
        end
    end

    assign level_o = level_q;
    assign req_o   = rise | (~fall & ((delay_hit & REPEAT_EN) | repeat_hit));

endmodule

// File: rtl/button_conditioner.sv
// Four debounced buttons arbitrated into one-hot single-cycle move pulses.
// MOVE is registered one edge after a request, i.e. on the same edge BTN_LEVEL rises for a press.
// No backpressure: same-cycle losing requests are dropped; held buttons retry on their next repeat.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               SW1,
    input  logic               SW2,
    input  logic               SW3,
    input  logic               SW4,
    output logic [NUM_BTN-1:0] BTN_LEVEL,
    output logic [NUM_BTN-1:0] MOVE
);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] req;
    logic [NUM_BTN-1:0] move_q, move_d;

    assign raw = {SW4, SW3, SW2, SW1};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_EN),
            .CNT_WIDTH       (CNT_WIDTH)
        ) u_ch (
            .clk_i   (CLK),
            .rst_i   (RST),
            .raw_i   (raw[g]),
            .level_o (level[g]),
            .req_o   (req[g])
        );
    end

    // Fixed priority SW1 > SW2 > SW3 > SW4.
    always_comb begin
        move_d = pick_highest(req);
    end

    // Output register keeps MOVE glitch-free and off any combinational path from the buttons.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) move_q <= '0;
        else     move_q <= move_d;
    end

    assign MOVE      = move_q;
    assign BTN_LEVEL = level;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic SW1 = 1'b0, SW2 = 1'b0, SW3 = 1'b0, SW4 = 1'b0;
    logic [3:0] lvl1, mv1, lvl0, mv0;

    int vecs = 0;
    int errs = 0;

    always #5 CLK = ~CLK;

    button_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                         .REPEAT_EN(1'b1), .CNT_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .SW1(SW1), .SW2(SW2), .SW3(SW3), .SW4(SW4),
        .BTN_LEVEL(lvl1), .MOVE(mv1));

    button_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                         .REPEAT_EN(1'b0), .CNT_WIDTH(8)) dut_norep (
        .CLK(CLK), .RST(RST), .SW1(SW1), .SW2(SW2), .SW3(SW3), .SW4(SW4),
        .BTN_LEVEL(lvl0), .MOVE(mv0));

    // ---------------- reference model ----------------
    // Level flips after D consecutive cycles of a synchronised mismatch; pulses occur
    // at hold time 0, RD, RD+RP, RD+2RP ... since the press; lowest index wins.
    bit [3:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_mv1 = '0, m_mv0 = '0;
    bit [3:0] m_raw, m_r1, m_r0;
    int       m_run[4];
    int       m_t[4];

    function automatic bit [3:0] lowest(input bit [3:0] r);
        for (int i = 0; i < 4; i++) if (r[i]) return 4'b0001 << i;
        return 4'b0000;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_mv1 = '0; m_mv0 = '0;
            for (int i = 0; i < 4; i++) begin m_run[i] = 0; m_t[i] = 0; end
        end else begin
            m_raw = {SW4, SW3, SW2, SW1};
            m_r1 = '0; m_r0 = '0;
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_lvl[i] = m_s2[i];
                        m_run[i] = 0;
                        if (m_lvl[i]) begin
                            m_t[i] = 0; m_r1[i] = 1'b1; m_r0[i] = 1'b1;
                        end
                        continue;
                    end
                end else begin
                    m_run[i] = 0;
                end
                if (m_lvl[i]) begin
                    m_t[i]++;
                    if (m_t[i] == RD || (m_t[i] > RD && (m_t[i] - RD) % RP == 0)) m_r1[i] = 1'b1;
                end
            end
            m_s2  = m_s1;
            m_s1  = m_raw;
            m_mv1 = lowest(m_r1);
            m_mv0 = lowest(m_r0);
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            vecs++;
            if ({lvl1, mv1, lvl0, mv0} !== 16'h0000) begin
                errs++;
                $display("FAIL reset: lvl=%b move=%b lvl0=%b move0=%b, required all 0", lvl1, mv1, lvl0, mv0);
            end
        end
        RST = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            vecs++;
            if ({lvl1, mv1, lvl0, mv0} !== {m_lvl, m_mv1, m_lvl, m_mv0}) begin
                errs++;
                $display("FAIL reset_idle c=%0d: got %b/%b/%b/%b required %b/%b/%b/%b",
                         c, lvl1, mv1, lvl0, mv0, m_lvl, m_mv1, m_lvl, m_mv0);
            end
        end
    endtask

    task automatic test_bounce();
        int last = -1, pulse_at = -1, rise_at = -1, npulse = 0;
        logic prev = 1'b0;
        for (int c = 0; c < 48; c++) begin
            @(negedge CLK);
            vecs++;
            if ({lvl1, mv1, lvl0, mv0} !== {m_lvl, m_mv1, m_lvl, m_mv0}) begin
                errs++;
                $display("FAIL bounce c=%0d: got %b/%b/%b/%b required %b/%b/%b/%b",
                         c, lvl1, mv1, lvl0, mv0, m_lvl, m_mv1, m_lvl, m_mv0);
            end
            if (c < 34 && mv1 != 4'b0000) begin
                npulse++;
                pulse_at = c;
                vecs++;
                if (mv1 !== 4'b0001) begin
                    errs++;
                    $display("FAIL bounce_value: move=%b required 0001", mv1);
                end
            end
            if (lvl1[0] === 1'b1 && prev === 1'b0 && rise_at < 0) rise_at = c;
            prev = lvl1[0];
            if (c <= 20 && c % 2 == 0) begin SW1 = ~SW1; last = c; end
            if (c == 40) SW1 = 1'b0;
        end
        vecs++;
        if (npulse != 1) begin errs++; $display("FAIL bounce_count: got %0d pulses required 1", npulse); end
        vecs++;
        if (pulse_at - last != 6) begin
            errs++; $display("FAIL bounce_latency: got %0d cycles required 6", pulse_at - last);
        end
        vecs++;
        if (rise_at != pulse_at) begin
            errs++; $display("FAIL bounce_level_align: level rose c=%0d pulse c=%0d", rise_at, pulse_at);
        end
    endtask

    task automatic test_auto_repeat();
        int press = -1, fall_at = -1;
        int offs[$];
        int exp_offs[7] = '{0, 10, 15, 20, 25, 30, 35};
        logic prev = 1'b0;
        SW4 = 1'b1;
        for (int c = 0; c < 90; c++) begin
            @(negedge CLK);
            vecs++;
            if ({lvl1, mv1, lvl0, mv0} !== {m_lvl, m_mv1, m_lvl, m_mv0}) begin
                errs++;
                $display("FAIL repeat c=%0d: got %b/%b/%b/%b required %b/%b/%b/%b",
                         c, lvl1, mv1, lvl0, mv0, m_lvl, m_mv1, m_lvl, m_mv0);
            end
            if (mv1 == 4'b1000 && press < 0) press = c;
            if (mv1 != 4'b0000) begin
                offs.push_back(c - press);
                vecs++;
                if (mv1 !== 4'b1000) begin errs++; $display("FAIL repeat_value: move=%b required 1000", mv1); end
            end
            if (lvl1[3] === 1'b0 && prev === 1'b1) fall_at = c;
            prev = lvl1[3];
            if (press >= 0 && c == press + 34) SW4 = 1'b0;
        end
        vecs++;
        if (offs.size() != 7) begin
            errs++; $display("FAIL repeat_count: got %0d pulses required 7", offs.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                vecs++;
                if (offs[i] != exp_offs[i]) begin
                    errs++; $display("FAIL repeat_offset[%0d]: got +%0d required +%0d", i, offs[i], exp_offs[i]);
                end
            end
        end
        vecs++;
        if (press < 0 || fall_at != press + 40) begin
            errs++; $display("FAIL repeat_release: level fell c=%0d required c=%0d", fall_at, press + 40);
        end
    endtask

    task automatic test_simultaneous();
        int first = -1, bad = 0, n2 = 0;
        SW2 = 1'b1; SW3 = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge CLK);
            vecs++;
            if ({lvl1, mv1, lvl0, mv0} !== {m_lvl, m_mv1, m_lvl, m_mv0}) begin
                errs++;
                $display("FAIL simul c=%0d: got %b/%b/%b/%b required %b/%b/%b/%b",
                         c, lvl1, mv1, lvl0, mv0, m_lvl, m_mv1, m_lvl, m_mv0);
            end
            if (mv1 != 4'b0000 && first < 0) first = int'(mv1);
            if (mv1[2] === 1'b1) bad++;
            if (mv1 === 4'b0010) n2++;
            if (c == 40) begin SW2 = 1'b0; SW3 = 1'b0; end
        end
        vecs++;
        if (first != 2) begin errs++; $display("FAIL simul_first: move=%0d required 2 (0010)", first); end
        vecs++;
        if (bad != 0) begin errs++; $display("FAIL simul_sw3_fired: got %0d pulses required 0", bad); end
        vecs++;
        if (n2 < 6) begin errs++; $display("FAIL simul_sw2_repeats: got %0d pulses required >= 6", n2); end
    endtask

    task automatic test_repeat_en0();
        int n0 = 0;
        SW3 = 1'b1;
        for (int c = 0; c < 70; c++) begin
            @(negedge CLK);
            vecs++;
            if ({lvl1, mv1, lvl0, mv0} !== {m_lvl, m_mv1, m_lvl, m_mv0}) begin
                errs++;
                $display("FAIL noreprep c=%0d: got %b/%b/%b/%b required %b/%b/%b/%b",
                         c, lvl1, mv1, lvl0, mv0, m_lvl, m_mv1, m_lvl, m_mv0);
            end
            if (mv0 != 4'b0000) begin
                n0++;
                vecs++;
                if (mv0 !== 4'b0100) begin errs++; $display("FAIL norepeat_value: move=%b required 0100", mv0); end
            end
            if (c == 50) SW3 = 1'b0;
        end
        vecs++;
        if (n0 != 1) begin errs++; $display("FAIL norepeat_count: got %0d pulses required 1", n0); end
    endtask

    task automatic test_async_reset();
        int seen = 0, lat = -1;
        bit hit = 0;
        SW1 = 1'b1;
        for (int c = 0; c < 60 && !hit; c++) begin
            @(negedge CLK);
            vecs++;
            if ({lvl1, mv1, lvl0, mv0} !== {m_lvl, m_mv1, m_lvl, m_mv0}) begin
                errs++;
                $display("FAIL arst_hold c=%0d: got %b/%b/%b/%b required %b/%b/%b/%b",
                         c, lvl1, mv1, lvl0, mv0, m_lvl, m_mv1, m_lvl, m_mv0);
            end
            if (mv1 == 4'b0001) seen++;
            if (seen == 2) begin
                hit = 1;
                #1 RST = 1'b1;
                #1;
                vecs++;
                if ({lvl1, mv1, lvl0, mv0} !== 16'h0000) begin
                    errs++;
                    $display("FAIL arst_immediate: lvl=%b move=%b lvl0=%b move0=%b required all 0",
                             lvl1, mv1, lvl0, mv0);
                end
            end
        end
        vecs++;
        if (!hit) begin errs++; $display("FAIL arst_timeout: saw %0d pulses required 2", seen); end
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(negedge CLK);
            vecs++;
            if ({lvl1, mv1, lvl0, mv0} !== {m_lvl, m_mv1, m_lvl, m_mv0}) begin
                errs++;
                $display("FAIL arst_release c=%0d: got %b/%b/%b/%b required %b/%b/%b/%b",
                         c, lvl1, mv1, lvl0, mv0, m_lvl, m_mv1, m_lvl, m_mv0);
            end
            if (mv1 == 4'b0001) lat = c;
        end
        vecs++;
        if (lat != D + 2) begin errs++; $display("FAIL arst_repress: pulse after %0d cycles required %0d", lat, D + 2); end
        SW1 = 1'b0;
        for (int c = 0; c < 12; c++) @(negedge CLK);
    endtask

    task automatic test_glitch();
        int nz = 0;
        SW2 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if ({lvl1, mv1} != 8'h00) nz++;
            if (c == 2) SW2 = 1'b0;
        end
        vecs++;
        if (nz != 0) begin errs++; $display("FAIL glitch: %0d cycles with output activity required 0", nz); end
    endtask

    task automatic test_random();
        int rate;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            vecs++;
            if ({lvl1, mv1, lvl0, mv0} !== {m_lvl, m_mv1, m_lvl, m_mv0}) begin
                errs++;
                $display("FAIL random c=%0d: got %b/%b/%b/%b required %b/%b/%b/%b",
                         c, lvl1, mv1, lvl0, mv0, m_lvl, m_mv1, m_lvl, m_mv0);
            end
            rate = (c < 1500) ? 5 : 40;
            if ($urandom_range(0, rate) == 0) SW1 = ~SW1;
            if ($urandom_range(0, rate) == 0) SW2 = ~SW2;
            if ($urandom_range(0, rate) == 0) SW3 = ~SW3;
            if ($urandom_range(0, rate) == 0) SW4 = ~SW4;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_bounce();
        test_auto_repeat();
        test_simultaneous();
        test_repeat_en0();
        test_async_reset();
        test_glitch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
